// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the ID stage and branch_resolve_unit.
// Covers ID operands, kill, predictor update, redirect handshake and perf counters.
interface branch_resolve_unit_if;
    // ID-stage instruction and operands
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_rj;
    logic [31:0] id_rd;
    logic [31:0] id_pred_target;
    logic        ex_flush;
    logic        id_kill;

    // Predictor update bus
    logic        upd_valid;
    logic        upd_is_bj;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    // Redirect handshake towards IF
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;

    modport master (
        output id_valid, id_stall, id_pc, id_inst, id_rj, id_rd, id_pred_target,
        output ex_flush, redirect_ready,
        input  id_kill, upd_valid, upd_is_bj, upd_pc, upd_taken, upd_target,
        input  redirect_valid, redirect_pc, perf_br_cnt, perf_mispred_cnt
    );

    modport slave (
        input  id_valid, id_stall, id_pc, id_inst, id_rj, id_rd, id_pred_target,
        input  ex_flush, redirect_ready,
        output id_kill, upd_valid, upd_is_bj, upd_pc, upd_taken, upd_target,
        output redirect_valid, redirect_pc, perf_br_cnt, perf_mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage LA32R branch resolver: decodes branches, checks the IF prediction, updates the predictor and redirects IF.
// Optional performance counters are enabled with the BRU_PERF_CNT_EN macro.
module branch_resolve_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    branch_resolve_unit_if.slave  bus
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_JIRL = 6'b010011;
    localparam logic [OP_W-1:0] OP_B    = 6'b010100;
    localparam logic [OP_W-1:0] OP_BL   = 6'b010101;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b010110;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b010111;
    localparam logic [OP_W-1:0] OP_BLT  = 6'b011000;
    localparam logic [OP_W-1:0] OP_BGE  = 6'b011001;
    localparam logic [OP_W-1:0] OP_BLTU = 6'b011010;
    localparam logic [OP_W-1:0] OP_BGEU = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REDIR = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;

    logic              upd_valid_q;
    logic              upd_is_bj_q;
    logic              upd_taken_q;
    logic [XLEN-1:0]   upd_pc_q;
    logic [XLEN-1:0]   upd_target_q;

    logic [OP_W-1:0]   opcode;
    logic [15:0]       offs16;
    logic [25:0]       offs26;
    logic [XLEN-1:0]   imm16;
    logic [XLEN-1:0]   imm26;
    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   cond_target;

    logic              is_bj;
    logic              taken;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   next_pc;

    logic              eq;
    logic              lt_s;
    logic              lt_u;

    logic              kill_c;
    logic              resolve_c;
    logic              mispredict_c;

    // Immediate extraction and the common adders
    assign opcode      = bus.id_inst[31:26];
    assign offs16      = bus.id_inst[25:10];
    assign offs26      = {bus.id_inst[9:0], bus.id_inst[25:10]};
    assign imm16       = {{14{offs16[15]}}, offs16, 2'b00};
    assign imm26       = {{4{offs26[25]}}, offs26, 2'b00};
    assign seq_pc      = bus.id_pc + XLEN'(4);
    assign cond_target = bus.id_pc + imm16;

    assign eq   = (bus.id_rj == bus.id_rd);
    assign lt_s = ($signed(bus.id_rj) < $signed(bus.id_rd));
    assign lt_u = (bus.id_rj < bus.id_rd);

    // Branch decode: direction and taken target
    always_comb begin
        is_bj  = 1'b0;
        taken  = 1'b0;
        target = seq_pc;
        unique case (opcode)
            OP_JIRL: begin
                is_bj  = 1'b1;
                taken  = 1'b1;
                target = bus.id_rj + imm16;
            end
            OP_B, OP_BL: begin
                is_bj  = 1'b1;
                taken  = 1'b1;
                target = bus.id_pc + imm26;
            end
            OP_BEQ: begin
                is_bj  = 1'b1;
                taken  = eq;
                target = cond_target;
            end
            OP_BNE: begin
                is_bj  = 1'b1;
                taken  = !eq;
                target = cond_target;
            end
            OP_BLT: begin
                is_bj  = 1'b1;
                taken  = lt_s;
                target = cond_target;
            end
            OP_BGE: begin
                is_bj  = 1'b1;
                taken  = !lt_s;
                target = cond_target;
            end
            OP_BLTU: begin
                is_bj  = 1'b1;
                taken  = lt_u;
                target = cond_target;
            end
            OP_BGEU: begin
                is_bj  = 1'b1;
                taken  = !lt_u;
                target = cond_target;
            end
            default: begin
                is_bj  = 1'b0;
                taken  = 1'b0;
                target = seq_pc;
            end
        endcase
    end

    assign next_pc = taken ? target : seq_pc;

    // Wrong-path squash: everything while redirecting, and anything but the target while waiting
    assign kill_c = bus.id_valid &
                    ((state_q == S_REDIR) |
                     ((state_q == S_WAIT) & (bus.id_pc != redirect_pc_q)));

    assign resolve_c    = bus.id_valid & !bus.id_stall & !kill_c & !bus.ex_flush;
    assign mispredict_c = resolve_c & (bus.id_pred_target != next_pc);

    // Redirect FSM; a flush from a later stage overrides any pending redirect
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
        end else if (bus.ex_flush) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mispredict_c) begin
                        state_q          <= S_REDIR;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= next_pc;
                    end
                end
                S_REDIR: begin
                    if (bus.redirect_ready) begin
                        state_q          <= S_WAIT;
                        redirect_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Only the redirect target can resolve here; others are killed
                    if (resolve_c) begin
                        if (mispredict_c) begin
                            state_q          <= S_REDIR;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= next_pc;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q          <= S_IDLE;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Predictor update bus, one-cycle strobe per resolved instruction
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            upd_valid_q  <= 1'b0;
            upd_is_bj_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_pc_q     <= RESET_PC;
            upd_target_q <= RESET_PC;
        end else begin
            upd_valid_q <= resolve_c;
            if (resolve_c) begin
                upd_is_bj_q  <= is_bj;
                upd_taken_q  <= taken;
                upd_pc_q     <= bus.id_pc;
                upd_target_q <= next_pc;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [XLEN-1:0] perf_br_q;
    logic [XLEN-1:0] perf_mispred_q;

    // Saturating event counters
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            perf_br_q      <= '0;
            perf_mispred_q <= '0;
        end else begin
            if (resolve_c && is_bj && (perf_br_q != {XLEN{1'b1}})) begin
                perf_br_q <= perf_br_q + XLEN'(1);
            end
            if (mispredict_c && (perf_mispred_q != {XLEN{1'b1}})) begin
                perf_mispred_q <= perf_mispred_q + XLEN'(1);
            end
        end
    end

    assign bus.perf_br_cnt      = perf_br_q;
    assign bus.perf_mispred_cnt = perf_mispred_q;
`else
    assign bus.perf_br_cnt      = '0;
    assign bus.perf_mispred_cnt = '0;
`endif

    assign bus.id_kill        = kill_c;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_is_bj      = upd_is_bj_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_target     = upd_target_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected updates/redirects, a monitor pops and compares.
module tb_branch_resolve_unit;

    localparam logic [31:0] RST_PC = 32'h1c000000;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BLTU = 6'b011010;

    logic cpu_clk = 1'b0;
    logic cpu_rstn;

    always #5 cpu_clk = ~cpu_clk;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(.RESET_PC(RST_PC)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bus      (bus)
    );

    typedef struct {
        logic        is_bj;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    upd_t        upd_q[$];
    logic [31:0] redir_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc16(input logic [5:0] op, input logic [15:0] offs);
        return {op, offs, 10'd0};
    endfunction

    function automatic logic [31:0] enc26(input logic [5:0] op, input logic [25:0] offs);
        return {op, offs[15:0], offs[25:16]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rj, input logic [31:0] rd, input logic [31:0] pred);
        bus.id_valid       = v;
        bus.id_pc          = pc;
        bus.id_inst        = inst;
        bus.id_rj          = rj;
        bus.id_rd          = rd;
        bus.id_pred_target = pred;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic exp_upd(input logic is_bj, input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_t e;
        e.is_bj  = is_bj;
        e.pc     = pc;
        e.taken  = taken;
        e.target = tgt;
        upd_q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge cpu_clk);
        #1;
    endtask

    // Monitor: compares every update pulse and redirect request against the queues
    upd_t        mon_e;
    logic        prev_rv = 1'b0;
    logic [31:0] held_rpc = 32'h0;

    always @(negedge cpu_clk) begin
        if (!cpu_rstn) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.upd_valid) begin
                if (upd_q.size() == 0) begin
                    check("upd_unexpected", 32'(bus.upd_valid), 32'd0);
                end else begin
                    mon_e = upd_q.pop_front();
                    check("upd_is_bj",  32'(bus.upd_is_bj), 32'(mon_e.is_bj));
                    check("upd_pc",     bus.upd_pc,         mon_e.pc);
                    check("upd_taken",  32'(bus.upd_taken), 32'(mon_e.taken));
                    check("upd_target", bus.upd_target,     mon_e.target);
                end
            end
            if (bus.redirect_valid && !prev_rv) begin
                if (redir_q.size() == 0) begin
                    check("redir_unexpected", 32'(bus.redirect_valid), 32'd0);
                end else begin
                    held_rpc = redir_q.pop_front();
                    check("redirect_pc", bus.redirect_pc, held_rpc);
                end
            end else if (bus.redirect_valid && prev_rv) begin
                check("redirect_pc_stable", bus.redirect_pc, held_rpc);
            end
            prev_rv = bus.redirect_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rstn           = 1'b0;
        bus.id_stall       = 1'b0;
        bus.ex_flush       = 1'b0;
        bus.redirect_ready = 1'b0;
        idle();
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_upd_valid",      32'(bus.upd_valid),      32'd0);
        check("rst_upd_is_bj",      32'(bus.upd_is_bj),      32'd0);
        check("rst_upd_taken",      32'(bus.upd_taken),      32'd0);
        check("rst_upd_pc",         bus.upd_pc,              RST_PC);
        check("rst_upd_target",     bus.upd_target,          RST_PC);
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_redirect_pc",    bus.redirect_pc,         RST_PC);
        check("rst_perf_br",        bus.perf_br_cnt,         32'd0);
        check("rst_perf_mispred",   bus.perf_mispred_cnt,    32'd0);
        nxt();
        cpu_rstn = 1'b1;

        // Correctly predicted branches back to back
        drive(1'b1, 32'h1c000000, enc16(OP_BEQ, 16'd4), 32'd5, 32'd6, 32'h1c000004);
        exp_upd(1'b1, 32'h1c000000, 1'b0, 32'h1c000004);
        @(negedge cpu_clk);
        check("beq_nt_kill", 32'(bus.id_kill), 32'd0);
        nxt();
        drive(1'b1, 32'h1c000040, enc16(OP_BLT, 16'hfffe), 32'hffffffff, 32'd1, 32'h1c000038);
        exp_upd(1'b1, 32'h1c000040, 1'b1, 32'h1c000038);
        nxt();
        drive(1'b1, 32'h1c000044, enc16(OP_BLTU, 16'hfffe), 32'hffffffff, 32'd1, 32'h1c000048);
        exp_upd(1'b1, 32'h1c000044, 1'b0, 32'h1c000048);
        nxt();
        drive(1'b1, 32'h1c000050, enc26(OP_B, 26'h100), 32'd0, 32'd0, 32'h1c000450);
        exp_upd(1'b1, 32'h1c000050, 1'b1, 32'h1c000450);
        nxt();

        // Stray ready with no redirect pending
        idle();
        bus.redirect_ready = 1'b1;
        nxt();
        bus.redirect_ready = 1'b0;
        @(negedge cpu_clk);
        check("ready_ignored_rv", 32'(bus.redirect_valid), 32'd0);
        check("idle_upd_valid",   32'(bus.upd_valid),      32'd0);
        nxt();

        // Stalled branch resolves exactly once
        drive(1'b1, 32'h1c000060, enc16(OP_BNE, 16'd8), 32'd1, 32'd2, 32'h1c000080);
        bus.id_stall = 1'b1;
        nxt();
        @(negedge cpu_clk);
        check("stall_no_upd", 32'(bus.upd_valid), 32'd0);
        nxt();
        bus.id_stall = 1'b0;
        exp_upd(1'b1, 32'h1c000060, 1'b1, 32'h1c000080);
        nxt();
        idle();
        @(negedge cpu_clk);
        check("stall_release_upd", 32'(bus.upd_valid), 32'd1);
        nxt();
        @(negedge cpu_clk);
        check("stall_single_upd", 32'(bus.upd_valid), 32'd0);
        nxt();

        // Mispredicted BEQ, held redirect, wrong-path squash
        drive(1'b1, 32'h1c000000, enc16(OP_BEQ, 16'd4), 32'd5, 32'd5, 32'h1c000004);
        exp_upd(1'b1, 32'h1c000000, 1'b1, 32'h1c000010);
        redir_q.push_back(32'h1c000010);
        nxt();
        drive(1'b1, 32'h1c000014, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000018);
        @(negedge cpu_clk);
        check("redir_c1_rv",   32'(bus.redirect_valid), 32'd1);
        check("redir_c1_kill", 32'(bus.id_kill),        32'd1);
        nxt();
        drive(1'b1, 32'h1c000018, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c00001c);
        @(negedge cpu_clk);
        check("redir_c2_rv",   32'(bus.redirect_valid), 32'd1);
        check("redir_c2_kill", 32'(bus.id_kill),        32'd1);
        nxt();
        idle();
        @(negedge cpu_clk);
        check("redir_c3_rv",   32'(bus.redirect_valid), 32'd1);
        check("redir_c3_kill", 32'(bus.id_kill),        32'd0);
        nxt();
        bus.redirect_ready = 1'b1;
        drive(1'b1, 32'h1c00001c, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000020);
        @(negedge cpu_clk);
        check("redir_c4_rv",   32'(bus.redirect_valid), 32'd1);
        check("redir_c4_pc",   bus.redirect_pc,         32'h1c000010);
        check("redir_c4_kill", 32'(bus.id_kill),        32'd1);
        nxt();
        bus.redirect_ready = 1'b0;
        drive(1'b1, 32'h1c000014, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000018);
        @(negedge cpu_clk);
        check("wait_rv_low",     32'(bus.redirect_valid), 32'd0);
        check("wait_kill_wrong", 32'(bus.id_kill),        32'd1);
        check("wait_no_upd",     32'(bus.upd_valid),      32'd0);
        nxt();
        drive(1'b1, 32'h1c000010, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000014);
        exp_upd(1'b0, 32'h1c000010, 1'b0, 32'h1c000014);
        @(negedge cpu_clk);
        check("wait_target_kill", 32'(bus.id_kill), 32'd0);
        nxt();

        // Non-branch mispredict, then a mispredicting JIRL straight from WAIT, then flush
        drive(1'b1, 32'h1c000020, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000100);
        exp_upd(1'b0, 32'h1c000020, 1'b0, 32'h1c000024);
        redir_q.push_back(32'h1c000024);
        @(negedge cpu_clk);
        check("add_idle_kill", 32'(bus.id_kill), 32'd0);
        nxt();
        bus.redirect_ready = 1'b1;
        idle();
        @(negedge cpu_clk);
        check("add_redir_pc", bus.redirect_pc, 32'h1c000024);
        nxt();
        bus.redirect_ready = 1'b0;
        drive(1'b1, 32'h1c000024, enc16(OP_JIRL, 16'hffff), 32'h1c001000, 32'd0, 32'h1c000028);
        exp_upd(1'b1, 32'h1c000024, 1'b1, 32'h1c000ffc);
        redir_q.push_back(32'h1c000ffc);
        @(negedge cpu_clk);
        check("jirl_rv_low", 32'(bus.redirect_valid), 32'd0);
        check("jirl_kill",   32'(bus.id_kill),        32'd0);
        nxt();
        drive(1'b1, 32'h1c000028, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c00002c);
        bus.ex_flush = 1'b1;
        @(negedge cpu_clk);
        check("jirl_redir_rv", 32'(bus.redirect_valid), 32'd1);
        check("jirl_redir_pc", bus.redirect_pc,         32'h1c000ffc);
        nxt();
        bus.ex_flush = 1'b0;
        drive(1'b1, 32'h1c000200, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000204);
        exp_upd(1'b0, 32'h1c000200, 1'b0, 32'h1c000204);
        @(negedge cpu_clk);
        check("flush_rv_low",    32'(bus.redirect_valid), 32'd0);
        check("flush_idle_kill", 32'(bus.id_kill),        32'd0);
        nxt();

        // Flush coinciding with a mispredict: no redirect, no update
        drive(1'b1, 32'h1c000300, enc26(OP_BL, 26'd4), 32'd0, 32'd0, 32'h1c000304);
        bus.ex_flush = 1'b1;
        nxt();
        bus.ex_flush = 1'b0;
        drive(1'b1, 32'h1c000320, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h1c000324);
        exp_upd(1'b0, 32'h1c000320, 1'b0, 32'h1c000324);
        @(negedge cpu_clk);
        check("flushmp_rv",   32'(bus.redirect_valid), 32'd0);
        check("flushmp_upd",  32'(bus.upd_valid),      32'd0);
        check("flushmp_kill", 32'(bus.id_kill),        32'd0);
        nxt();
        idle();
        @(negedge cpu_clk);
        check("post_flush_upd", 32'(bus.upd_valid), 32'd1);
`ifdef BRU_PERF_CNT_EN
        check("perf_br_cnt",      bus.perf_br_cnt,      32'd7);
        check("perf_mispred_cnt", bus.perf_mispred_cnt, 32'd3);
`else
        check("perf_br_off",      bus.perf_br_cnt,      32'd0);
        check("perf_mispred_off", bus.perf_mispred_cnt, 32'd0);
`endif
        nxt();

        // Reset asserted while a redirect is pending
        drive(1'b1, 32'h1c000400, enc16(OP_ADD, 16'h0400), 32'd0, 32'd0, 32'h0);
        exp_upd(1'b0, 32'h1c000400, 1'b0, 32'h1c000404);
        redir_q.push_back(32'h1c000404);
        nxt();
        idle();
        @(negedge cpu_clk);
        check("pre_reset_rv", 32'(bus.redirect_valid), 32'd1);
        nxt();
        cpu_rstn = 1'b0;
        #1;
        check("mid_rst_rv",         32'(bus.redirect_valid), 32'd0);
        check("mid_rst_redir_pc",   bus.redirect_pc,         RST_PC);
        check("mid_rst_upd_pc",     bus.upd_pc,              RST_PC);
        check("mid_rst_upd_target", bus.upd_target,          RST_PC);
        check("mid_rst_perf_br",    bus.perf_br_cnt,         32'd0);
        nxt();
        cpu_rstn = 1'b1;
        nxt();

`ifdef BRU_PERF_CNT_EN
        // Saturation of the branch counter
        force dut.perf_br_q = 32'hffffffff;
        nxt();
        release dut.perf_br_q;
        drive(1'b1, 32'h1c000000, enc16(OP_BEQ, 16'd4), 32'd5, 32'd6, 32'h1c000004);
        exp_upd(1'b1, 32'h1c000000, 1'b0, 32'h1c000004);
        nxt();
        idle();
        @(negedge cpu_clk);
        check("perf_br_sat",       bus.perf_br_cnt,      32'hffffffff);
        check("perf_mispred_zero", bus.perf_mispred_cnt, 32'd0);
        nxt();
`endif

        repeat (2) nxt();
        check("upd_q_drained",   32'(upd_q.size()),   32'd0);
        check("redir_q_drained", 32'(redir_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
